// File: rtl/fir_symmetric_mc.sv
// Time-multiplexed symmetric FIR: one pre-adder and one multiplier iterate over
// the folded taps of each sample, and all channels share that datapath.
module fir_symmetric_mc #(
  parameter int N_TAPS      = 51,
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int FRAC_BITS   = 15,
  parameter int OUT_WIDTH   = 16,
  localparam int M   = (N_TAPS + 1) / 2,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW  = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CHW-1:0]         in_chan,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic [COEFF_WIDTH-1:0] coef_data,
  output logic                   coef_err,
  output logic                   out_valid,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [CHW-1:0]         out_chan,
  output logic                   out_sat,
  output logic [1:0]             dbg_state
);

  localparam int PW   = $clog2(N_TAPS);
  localparam int PRW  = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int ACCW = DATA_WIDTH + COEFF_WIDTH + 1 + $clog2(M);

  localparam logic [CHW:0]         CH_LIM   = (CHW + 1)'(CHANNELS);
  localparam logic [AW:0]          M_LIM    = (AW + 1)'(M);
  localparam logic [AW-1:0]        K_LAST   = AW'(M - 1);
  localparam logic [PW-1:0]        PTR_LAST = PW'(N_TAPS - 1);
  localparam logic [PW:0]          NT       = (PW + 1)'(N_TAPS);
  localparam logic [PW:0]          ONE      = (PW + 1)'(1);
  localparam logic signed [ACCW:0] RND      = (ACCW + 1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACCW:0] OMAX     = (ACCW + 1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [ACCW:0] OMIN     = (ACCW + 1)'(-(2 ** (OUT_WIDTH - 1)));

  // in_valid/in_ready: a sample transfers on any rising edge where both are
  // high; in_ready is high exactly while the FSM is idle. Outputs have no
  // backpressure: out_valid is a single-cycle pulse the consumer must take.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          k_q, k_d;
  logic [PW-1:0]          cur_ptr_q, cur_ptr_d;
  logic [CHW-1:0]         cur_chan_q, cur_chan_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CHW-1:0]         out_chan_q, out_chan_d;
  logic                   out_sat_q, out_sat_d;
  logic                   coef_err_q, coef_err_d;

  logic [PW-1:0]                 wptr_q [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  dl_q   [CHANNELS][N_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_q [M];

  logic                   sample_we, coef_ok;
  logic [PW-1:0]          wptr_nxt;
  logic [PW:0]            pe, ke, sum_b;
  logic [PW-1:0]          idx_a, idx_b;
  logic signed [DATA_WIDTH:0] xa_e, xb_e, pre;
  logic signed [PRW-1:0]  ca, pa, prod;
  logic signed [ACCW:0]   rsum, rsh;
  logic                   sat_hi, sat_lo;

  assign in_ready  = (state_q == S_IDLE);
  assign sample_we = in_ready && in_valid && ({1'b0, in_chan} < CH_LIM);
  assign coef_ok   = coef_we && in_ready && ({1'b0, coef_addr} < M_LIM);
  assign wptr_nxt  = (wptr_q[in_chan] == PTR_LAST) ? '0 : wptr_q[in_chan] + 1'b1;

  // Sample n sits at cur_ptr; x[n-k] is k slots behind it and its mirror
  // x[n-(N-1-k)] is k+1 slots ahead modulo N. At the centre tap both coincide.
  always_comb begin
    pe    = {1'b0, cur_ptr_q};
    ke    = (PW + 1)'(k_q);
    idx_a = (pe >= ke) ? PW'(pe - ke) : PW'(pe + NT - ke);
    sum_b = pe + ke + ONE;
    idx_b = (sum_b >= NT) ? PW'(sum_b - NT) : PW'(sum_b);
    xa_e  = {dl_q[cur_chan_q][idx_a][DATA_WIDTH-1], dl_q[cur_chan_q][idx_a]};
    xb_e  = {dl_q[cur_chan_q][idx_b][DATA_WIDTH-1], dl_q[cur_chan_q][idx_b]};
    pre   = (k_q == K_LAST) ? xa_e : xa_e + xb_e;
    ca    = PRW'(coef_q[k_q]);
    pa    = PRW'(pre);
    prod  = ca * pa;
    rsum  = $signed({acc_q[ACCW-1], acc_q}) + RND;
    rsh   = rsum >>> FRAC_BITS;
    sat_hi = (rsh > OMAX);
    sat_lo = (rsh < OMIN);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    cur_ptr_d   = cur_ptr_q;
    cur_chan_d  = cur_chan_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_sat_d   = out_sat_q;
    coef_err_d  = coef_we && !coef_ok;
    case (state_q)
      S_IDLE: begin
        if (sample_we) begin
          state_d    = S_MAC;
          k_d        = '0;
          acc_d      = '0;
          cur_ptr_d  = wptr_q[in_chan];
          cur_chan_d = in_chan;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACCW'(prod);
        if (k_q == K_LAST) state_d = S_OUT;
        else               k_d     = k_q + 1'b1;
      end
      S_OUT: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        out_chan_d  = cur_chan_q;
        out_sat_d   = sat_hi || sat_lo;
        if (sat_hi)      out_data_d = OUT_WIDTH'(OMAX);
        else if (sat_lo) out_data_d = OUT_WIDTH'(OMIN);
        else             out_data_d = OUT_WIDTH'(rsh);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cur_ptr_q   <= '0;
      cur_chan_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_sat_q   <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c] <= '0;
        for (int i = 0; i < N_TAPS; i++) dl_q[c][i] <= '0;
      end
      for (int k = 0; k < M; k++) coef_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cur_ptr_q   <= cur_ptr_d;
      cur_chan_q  <= cur_chan_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_sat_q   <= out_sat_d;
      coef_err_q  <= coef_err_d;
      if (sample_we) begin
        dl_q[in_chan][wptr_q[in_chan]] <= in_data;
        wptr_q[in_chan]                <= wptr_nxt;
      end
      if (coef_ok) coef_q[coef_addr] <= coef_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_sat   = out_sat_q;
  assign coef_err  = coef_err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fir_symmetric_mc.md
# fir_symmetric_mc

Multi-channel, time-multiplexed symmetric FIR filter with runtime-loadable coefficients. It is the parametrised successor to our fixed 51-tap Q15 filters. It exploits coefficient symmetry with one pre-adder and one multiplier, iterating over (N_TAPS+1)/2 folded taps per sample. Any mirror-symmetric response (low/high/band-pass, band-stop) is selected by loading coefficients, and CHANNELS independent streams share one datapath. It sits between the ADC sample interface and downstream decimation/processing.

## Interface
- N_TAPS, 51, tap count; must be odd, ≥3. M = (N_TAPS+1)/2 folded taps.
- CHANNELS, 2, independent channels, ≥1.
- DATA_WIDTH, 16, signed input sample width.
- COEFF_WIDTH, 16, signed coefficient width.
- FRAC_BITS, 15, coefficient fractional bits (Q format); ≥1.
- OUT_WIDTH, 16, signed saturated output width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  active-high synchronous reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_WIDTH  signed sample.
- in_chan  in  max(1,clog2(CHANNELS))  channel of in_data.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  max(1,clog2(M))  folded tap index k; k = M-1 is the centre tap.
- coef_data  in  COEFF_WIDTH  signed coefficient h[k] (= h[N_TAPS-1-k]).
- coef_err  out  1  one-cycle pulse: the write was rejected.
- out_valid  out  1  one-cycle result pulse.
- out_data  out  OUT_WIDTH  filtered, rounded, saturated sample.
- out_chan  out  max(1,clog2(CHANNELS))  channel of out_data.
- out_sat  out  1  saturation occurred for this out_data.

## Operation
- State machine: IDLE → MAC → OUT → IDLE.
- in_ready = 1 only in IDLE. A sample is accepted on an edge where in_valid & in_ready.
  - in_data is written at the channel's write pointer in its circular delay line (N_TAPS entries).
  - The pointer then advances, wrapping from N_TAPS-1 to 0.
  - in_chan ≥ CHANNELS: sample dropped, state stays IDLE, nothing is written.
- MAC: M cycles, k = 0..M-1, accumulator cleared on entry.
  - k < M-1: pre = x[n-k] + x[n-(N_TAPS-1-k)], width DATA_WIDTH+1.
  - k = M-1: pre = x[n-(N_TAPS-1)/2], sign-extended.
  - acc += h[k]·pre.
  - acc width = DATA_WIDTH+COEFF_WIDTH+1+clog2(M), so it never overflows.
- OUT:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift).
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat = 1 if clipped.
  - Register out_data, out_chan and out_sat; pulse out_valid.
- There is no output backpressure. The consumer must take out_valid pulses.
- Coefficient writes:
  - Accepted only when the state is IDLE and coef_addr < M. The write is visible to the next accepted sample.
  - Otherwise coef_err pulses on the next cycle and the stored value is unchanged.
  - A write and a sample accept on the same edge are both performed. That sample uses the new coefficient.
- Reset values:
  - Delay lines, write pointers and coefficients are 0. State is IDLE.
  - in_ready = 1 after reset; out_valid = 0, out_data = 0, out_chan = 0, out_sat = 0, coef_err = 0.
- Reset mid-MAC or mid-OUT: the operation is aborted, no out_valid is produced, and all state above is cleared.

## Timing
- Edge E0 accepts the sample. Edges E1..EM run the M MAC steps. Edge E(M+1) registers the result.
- out_valid is high for one cycle, E(M+1) to E(M+2). in_ready is high again from E(M+1).
- Latency is M+1 clocks; throughput is one sample per M+2 clocks, shared across channels.
  - Defaults: 27 clocks latency, one sample per 28 clocks.
- Group delay is (N_TAPS-1)/2 samples per channel.
- coef_err is asserted the cycle after the offending coef_we, for 1 cycle.

## Test plan
- Reset: hold rst 3 cycles mid-MAC, then release. Next cycle: in_ready = 1, out_valid = 0, out_data = 0, and no late out_valid appears.
- Centre tap: write h[25] = 16384, then feed ch0 the sequence 1000, 0, 0, … Outputs 0–24 are 0, output 25 is 500, outputs 26+ are 0; out_chan = 0 throughout.
- Symmetry and rounding: write h[0] = 32767, other taps 0. Feed ch0 20000 then zeros. Outputs 0 and 50 are 19999, all others 0.
- Channel isolation: write h[25] = 16384. Interleave ch0 impulse 1000 with ch1 zeros. All ch1 outputs are 0; the ch0 response matches the centre-tap case; each out_chan matches its input.
- Saturation: all 26 coefficients 32767, constant input 32767. After 51 samples, out_data = 32767 and out_sat = 1. With input -32768: out_data = -32768 and out_sat = 1.
- Illegal writes: coef_we during MAC, or coef_addr = 26 while IDLE. coef_err pulses one cycle after each, and a later impulse shows the coefficients unchanged.
